// File: rtl/isr_priority_resolver.sv
// 8259 priority resolver and in-service register: rotating-priority arbitration,
// two-pulse INTA acknowledge with vector generation, and EOI/AEOI handling.
module isr_priority_resolver (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IRR_Output,
    input  logic [7:0] IMR,
    input  logic       inta_pulse,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       auto_eoi,
    input  logic       rotate_on_eoi,
    input  logic [4:0] vector_base,
    output logic       INT,
    output logic [7:0] clear_IRR,
    output logic [7:0] ISR,
    output logic [7:0] vector_out,
    output logic       vector_valid
);

    typedef enum logic {IDLE = 1'b0, WAIT2 = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [2:0] lowest_prio_q, lowest_prio_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic [7:0] isr_q, isr_d;
    logic       int_q, int_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_valid_q, vector_valid_d;

    logic [7:0] cand;
    logic       win_valid, isr_valid, outranks;
    logic [2:0] win_lvl, isr_lvl;
    logic [7:0] isr_set, isr_clr;

    // Rotate the request word so the highest-priority level sits at bit 0, then
    // take the lowest set bit; returns {valid, level}.
    function automatic logic [3:0] highest(input logic [7:0] req, input logic [2:0] lp);
        logic [7:0] rot;
        logic [3:0] res;
        rot = 8'({req, req} >> (4'(lp) + 4'd1));
        res = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (rot[i-1]) res = {1'b1, lp + 3'(i)};
        end
        return res;
    endfunction

    function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

    always_comb begin
        cand                 = IRR_Output & ~IMR;
        {win_valid, win_lvl} = highest(cand, lowest_prio_q);
        {isr_valid, isr_lvl} = highest(isr_q, lowest_prio_q);
        outranks = win_valid &&
                   (!isr_valid || (rank_of(win_lvl, lowest_prio_q) < rank_of(isr_lvl, lowest_prio_q)));
    end

    always_comb begin
        state_d        = state_q;
        lowest_prio_d  = lowest_prio_q;
        level_d        = level_q;
        spurious_d     = spurious_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        clear_irr_d    = '0;
        isr_set        = '0;
        isr_clr        = '0;

        case (state_q)
            IDLE: begin
                if (inta_pulse) begin
                    state_d = WAIT2;
                    if (int_q && win_valid) begin
                        level_d          = win_lvl;
                        spurious_d       = 1'b0;
                        isr_set[win_lvl] = 1'b1;
                        clear_irr_d      = isr_set;
                    end else begin
                        level_d    = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            WAIT2: begin
                if (inta_pulse) begin
                    state_d        = IDLE;
                    vector_d       = {vector_base, level_q};
                    vector_valid_d = 1'b1;
                    if (auto_eoi && !spurious_q) begin
                        isr_clr[level_q] = 1'b1;
                        if (rotate_on_eoi) lowest_prio_d = level_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // EOI targets come from the pre-edge ISR; a set in the same cycle survives.
        if (eoi_specific) begin
            isr_clr[eoi_level] = 1'b1;
        end else if (eoi_nonspecific && isr_valid) begin
            isr_clr[isr_lvl] = 1'b1;
            if (rotate_on_eoi) lowest_prio_d = isr_lvl;
        end

        isr_d = (isr_q & ~isr_clr) | isr_set;
        int_d = (state_d == IDLE) && outranks;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            lowest_prio_q  <= 3'd7;
            level_q        <= '0;
            spurious_q     <= 1'b0;
            isr_q          <= '0;
            int_q          <= 1'b0;
            clear_irr_q    <= '0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lowest_prio_q  <= lowest_prio_d;
            level_q        <= level_d;
            spurious_q     <= spurious_d;
            isr_q          <= isr_d;
            int_q          <= int_d;
            clear_irr_q    <= clear_irr_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
        end
    end

    assign INT          = int_q;
    assign clear_IRR    = clear_irr_q;
    assign ISR          = isr_q;
    assign vector_out   = vector_q;
    assign vector_valid = vector_valid_q;

endmodule

// File: tb/tb_isr_priority_resolver.sv
// Bench for isr_priority_resolver: directed INTA/EOI scenarios with literal
// expectations, plus a cycle model checked against every output each cycle.
module tb_isr_priority_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IRR_Output, IMR;
    logic       inta_pulse, eoi_nonspecific, eoi_specific;
    logic [2:0] eoi_level;
    logic       auto_eoi, rotate_on_eoi;
    logic [4:0] vector_base;
    logic       INT, vector_valid;
    logic [7:0] clear_IRR, ISR, vector_out;

    int n_cmp  = 0;
    int n_fail = 0;
    bit live   = 1'b0;

    isr_priority_resolver dut (
        .clk(clk), .reset(reset), .IRR_Output(IRR_Output), .IMR(IMR),
        .inta_pulse(inta_pulse), .eoi_nonspecific(eoi_nonspecific),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .auto_eoi(auto_eoi),
        .rotate_on_eoi(rotate_on_eoi), .vector_base(vector_base), .INT(INT),
        .clear_IRR(clear_IRR), .ISR(ISR), .vector_out(vector_out),
        .vector_valid(vector_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: priority is a walk from lowest_prio+1 around the ring.
    bit [7:0] m_isr, m_clr, m_vec;
    bit       m_int, m_vv, m_wait, m_spur;
    bit [2:0] m_L;
    int       m_lp;

    function automatic int best(input bit [7:0] v, input int lp);
        for (int k = 1; k <= 8; k++) begin
            if (v[(lp + k) % 8]) return (lp + k) % 8;
        end
        return -1;
    endfunction

    function automatic int rank(input int l, input int lp);
        return (l - lp + 7) % 8;
    endfunction

    always @(posedge clk) begin : mdl
        bit [7:0] cand, nisr, nset, nclrm, nclr;
        bit       nwait, nvv, nint;
        int       w, h, nlp;
        if (reset) begin
            m_isr <= '0; m_clr <= '0; m_vec <= '0; m_int <= 0; m_vv <= 0;
            m_wait <= 0; m_spur <= 0; m_L <= '0; m_lp <= 7;
        end else begin
            cand = IRR_Output & ~IMR;
            w = best(cand, m_lp);
            h = best(m_isr, m_lp);
            nset = '0; nclrm = '0; nclr = '0; nvv = 0; nwait = m_wait; nlp = m_lp;
            if (!m_wait && inta_pulse) begin
                nwait = 1;
                if (m_int && w >= 0) begin
                    nset[w] = 1; nclr[w] = 1; m_L <= 3'(w); m_spur <= 0;
                end else begin
                    m_L <= 3'd7; m_spur <= 1;
                end
            end else if (m_wait && inta_pulse) begin
                nwait = 0; nvv = 1;
                m_vec <= {vector_base, m_L};
                if (auto_eoi && !m_spur) begin
                    nclrm[m_L] = 1;
                    if (rotate_on_eoi) nlp = m_L;
                end
            end
            if (eoi_specific) nclrm[eoi_level] = 1;
            else if (eoi_nonspecific && h >= 0) begin
                nclrm[h] = 1;
                if (rotate_on_eoi) nlp = h;
            end
            nisr = (m_isr & ~nclrm) | nset;
            nint = !nwait && w >= 0 && (h < 0 || rank(w, m_lp) < rank(h, m_lp));
            m_isr <= nisr; m_clr <= nclr; m_vv <= nvv; m_wait <= nwait;
            m_int <= nint; m_lp <= nlp;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_INT", {7'b0, INT}, {7'b0, m_int});
            chk("m_clear_IRR", clear_IRR, m_clr);
            chk("m_ISR", ISR, m_isr);
            chk("m_vector_out", vector_out, m_vec);
            chk("m_vector_valid", {7'b0, vector_valid}, {7'b0, m_vv});
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic inta();
        inta_pulse = 1; cyc(); inta_pulse = 0;
    endtask

    initial begin
        reset = 1; IRR_Output = '0; IMR = '0; inta_pulse = 0; eoi_nonspecific = 0;
        eoi_specific = 0; eoi_level = '0; auto_eoi = 0; rotate_on_eoi = 0;
        vector_base = 5'b01000;
        cyc(); live = 1; cyc(); reset = 0;
        chk("rst_INT", {7'b0, INT}, 8'h00);
        chk("rst_ISR", ISR, 8'h00);
        chk("rst_clear", clear_IRR, 8'h00);
        chk("rst_vec", vector_out, 8'h00);
        chk("rst_vv", {7'b0, vector_valid}, 8'h00);

        // Basic acknowledge of IR1 over IR4
        IRR_Output = 8'b00010010; cyc();
        chk("t1_INT", {7'b0, INT}, 8'h01);
        inta(); IRR_Output = 8'b00010000;
        chk("t1_ISR", ISR, 8'h02);
        chk("t1_clear", clear_IRR, 8'h02);
        chk("t1_INT_wait2", {7'b0, INT}, 8'h00);
        cyc();
        chk("t1_clear_pulse", clear_IRR, 8'h00);
        inta();
        chk("t1_vec", vector_out, 8'h41);
        chk("t1_vv", {7'b0, vector_valid}, 8'h01);
        cyc();
        chk("t1_vv_drop", {7'b0, vector_valid}, 8'h00);
        chk("t1_vec_hold", vector_out, 8'h41);
        chk("t2_INT_lower", {7'b0, INT}, 8'h00);

        // IR0 outranks IR1 in service; then specific EOI
        IRR_Output = 8'b00010001; cyc();
        chk("t2_INT_higher", {7'b0, INT}, 8'h01);
        IRR_Output = '0; eoi_specific = 1; eoi_level = 3'd1; cyc(); eoi_specific = 0;
        chk("t2_seoi_ISR", ISR, 8'h00);

        // Masking
        IMR = 8'b00010000; IRR_Output = 8'b00010000; cyc();
        chk("t3_masked", {7'b0, INT}, 8'h00);
        IMR = '0; cyc();
        chk("t3_unmasked", {7'b0, INT}, 8'h01);
        IRR_Output = '0; cyc();
        chk("t3_drop", {7'b0, INT}, 8'h00);

        // Spurious acknowledge
        inta();
        chk("t4_ISR", ISR, 8'h00);
        chk("t4_clear", clear_IRR, 8'h00);
        inta();
        chk("t4_vec", vector_out, 8'h47);

        // Rotate on non-specific EOI
        IRR_Output = 8'b00001000; cyc();
        inta(); IRR_Output = '0;
        chk("t5_ISR3", ISR, 8'h08);
        inta();
        chk("t5_vec3", vector_out, 8'h43);
        rotate_on_eoi = 1; eoi_nonspecific = 1; cyc(); eoi_nonspecific = 0;
        chk("t5_nseoi", ISR, 8'h00);
        IRR_Output = 8'b00010100; cyc();
        chk("t5_INT", {7'b0, INT}, 8'h01);
        inta(); IRR_Output = 8'b00000100;
        chk("t5_ISR4", ISR, 8'h10);
        inta();
        chk("t5_vec4", vector_out, 8'h44);
        rotate_on_eoi = 0; IRR_Output = '0; eoi_nonspecific = 1; cyc(); eoi_nonspecific = 0;
        chk("t5_clr4", ISR, 8'h00);

        // Automatic EOI on IR5
        auto_eoi = 1; IRR_Output = 8'b00100000; cyc();
        inta(); IRR_Output = '0;
        chk("t6_ISR_set", ISR, 8'h20);
        inta();
        chk("t6_ISR_aeoi", ISR, 8'h00);
        chk("t6_vec", vector_out, 8'h45);
        auto_eoi = 0;

        // Reset in WAIT2
        IRR_Output = 8'b00100000; cyc();
        inta(); IRR_Output = '0;
        chk("t7_ISR", ISR, 8'h20);
        reset = 1; inta_pulse = 1; cyc(); reset = 0; inta_pulse = 0;
        chk("t7_ISR_rst", ISR, 8'h00);
        chk("t7_vv_rst", {7'b0, vector_valid}, 8'h00);
        chk("t7_vec_rst", vector_out, 8'h00);
        IRR_Output = 8'b10000001; cyc();
        inta(); IRR_Output = 8'b10000000;
        chk("t7_prio_rst", ISR, 8'h01);
        inta();
        chk("t7_vec0", vector_out, 8'h40);

        // Both EOI strobes: specific one wins
        IRR_Output = '0; eoi_specific = 1; eoi_nonspecific = 1; eoi_level = 3'd5; cyc();
        eoi_specific = 0; eoi_nonspecific = 0;
        chk("t8_both_eoi", ISR, 8'h01);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
